control_pipe: RTL and testbench

Pipelined, parametrised control unit for the accumulator-style core. It decodes the opcode and function fields in the ID stage and registers the full control bundle into an ID/EX control register. It also detects load-use hazards, stretches loads across a configurable memory latency and squashes the ID instruction on a taken branch or jump. It sits between the IF/ID register and the EX stage. It drives the PC/IF-ID freeze and a saturating stall-cycle counter for performance debug.

---
 rtl/control_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_control_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// ID-stage control unit: decodes opcode/func into an ID/EX control register,
// stretches loads over LDLAT wait cycles, inserts load-use bubbles and flushes on branches.
module control_pipe #(
  parameter int MCB   = 3,
  parameter int OPW   = 3,
  parameter int RAW   = 3,
  parameter int LDLAT = 1,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [MCB-1:0]  opcode,
  input  logic [1:0]      func,
  input  logic [RAW-1:0]  src_a,
  input  logic [RAW-1:0]  src_b,
  input  logic [RAW-1:0]  dst_addr,
  input  logic            branch_taken,
  output logic            stall_f,
  output logic            ex_valid,
  output logic            ex_reg_dst,
  output logic            ex_ls,
  output logic            ex_isig,
  output logic            ex_swap,
  output logic            ex_branch,
  output logic            ex_memto_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_jump,
  output logic [OPW-1:0]  ex_alu_op,
  output logic [RAW-1:0]  ex_dst,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic           valid;
    logic           reg_dst;
    logic           ls;
    logic           isig;
    logic           swap;
    logic           branch;
    logic           memto_reg;
    logic           mem_write;
    logic           alu_src;
    logic           reg_write;
    logic           jump;
    logic [OPW-1:0] alu_op;
    logic [RAW-1:0] dst;
  } ctrl_t;

  typedef enum logic {RUN, MWAIT} state_t;

  localparam ctrl_t      BUBBLE  = '0;
  localparam logic [2:0] LDLAT_W = 3'(LDLAT);

  state_t     state, state_n;
  logic [2:0] wcnt, wcnt_n;
  ctrl_t      ex, ex_n, dec;
  logic [2:0] op3;
  logic       op_in_range;
  logic       hazard;

  assign op3 = opcode[2:0];

  // Opcodes with any bit set above bit 2 are not part of the instruction set.
  generate
    if (MCB > 3) begin : g_wide_op
      assign op_in_range = (opcode[MCB-1:3] == '0);
    end else begin : g_narrow_op
      assign op_in_range = 1'b1;
    end
  endgenerate

  function automatic logic [OPW-1:0] alu_code(input logic [2:0] code);
    return OPW'(code);
  endfunction

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case/if leaves it unassigned and no latch is inferred.
  always_comb begin
    dec           = BUBBLE;
    dec.valid     = 1'b1;
    dec.reg_write = 1'b1;
    dec.alu_op    = '1;
    dec.dst       = dst_addr;
    unique case (op3)
      3'b000: begin
        dec.reg_dst = 1'b1;
        dec.alu_op  = alu_code(3'b000);
      end
      3'b001: begin
        dec.branch    = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = alu_code(3'b001);
        dec.reg_write = 1'b0;
      end
      3'b010: begin
        dec.reg_dst = 1'b1;
        dec.alu_op  = alu_code(3'b010);
      end
      3'b011: begin
        dec.reg_dst = 1'b1;
        dec.alu_src = 1'b1;
        dec.alu_op  = alu_code(3'b011);
      end
      3'b100: begin
        dec.memto_reg = 1'b1;
        dec.ls        = 1'b1;
        dec.alu_src   = 1'b1;
        dec.isig      = 1'b1;
        dec.alu_op    = alu_code(3'b100);
      end
      3'b101: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.swap      = 1'b1;
        dec.isig      = 1'b1;
        dec.alu_op    = alu_code(3'b101);
        dec.reg_write = 1'b0;
      end
      3'b110: begin
        dec.jump      = 1'b1;
        dec.alu_op    = alu_code(3'b110);
        dec.reg_write = 1'b0;
      end
      3'b111: begin
        dec.reg_dst = 1'b1;
        dec.alu_op  = alu_code(3'b111);
        if (func == 2'b10) dec.swap = 1'b1;
        else               dec.isig = 1'b1;
      end
    endcase
    if (!(in_valid && op_in_range)) dec = BUBBLE;
  end

  // Register 0 is compared like any other address: no special case.
  assign hazard = ex.valid && ex.ls && ex.reg_write && in_valid &&
                  ((ex.dst == src_a) || (ex.dst == src_b));

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    ex_n    = ex;
    stall_f = 1'b0;
    unique case (state)
      MWAIT: begin
        // The load owns EX; a branch resolved elsewhere cannot be in EX now.
        stall_f = 1'b1;
        wcnt_n  = wcnt - 3'd1;
        if (wcnt <= 3'd1) state_n = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          ex_n = BUBBLE;
        end else if (hazard) begin
          ex_n    = BUBBLE;
          stall_f = 1'b1;
        end else begin
          ex_n = dec;
          if (dec.valid && dec.ls && (LDLAT != 0)) begin
            state_n = MWAIT;
            wcnt_n  = LDLAT_W;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wcnt      <= '0;
      ex        <= BUBBLE;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      ex    <= ex_n;
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

  assign ex_valid     = ex.valid;
  assign ex_reg_dst   = ex.reg_dst;
  assign ex_ls        = ex.ls;
  assign ex_isig      = ex.isig;
  assign ex_swap      = ex.swap;
  assign ex_branch    = ex.branch;
  assign ex_memto_reg = ex.memto_reg;
  assign ex_mem_write = ex.mem_write;
  assign ex_alu_src   = ex.alu_src;
  assign ex_reg_write = ex.reg_write;
  assign ex_jump      = ex.jump;
  assign ex_alu_op    = ex.alu_op;
  assign ex_dst       = ex.dst;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: three instances (LDLAT 1/2/0, one with a 4-bit counter)
// share stimulus and are each compared every cycle against a per-instance reference model.
module tb_control_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] opcode = '0;
  logic [1:0] func = '0;
  logic [2:0] src_a = '0, src_b = '0, dst_addr = '0;
  logic       branch_taken = 1'b0;

  logic       o_stall [3], o_valid [3], o_reg_dst [3], o_ls [3], o_isig [3], o_swap [3];
  logic       o_branch [3], o_memto_reg [3], o_mem_write [3], o_alu_src [3];
  logic       o_reg_write [3], o_jump [3];
  logic [2:0] o_alu_op [3], o_dst [3];
  logic [15:0] o_cnt0, o_cnt2;
  logic [3:0]  o_cnt1;

  control_pipe #(.LDLAT(1), .CNTW(16)) u_lat1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .func(func),
    .src_a(src_a), .src_b(src_b), .dst_addr(dst_addr), .branch_taken(branch_taken),
    .stall_f(o_stall[0]), .ex_valid(o_valid[0]), .ex_reg_dst(o_reg_dst[0]), .ex_ls(o_ls[0]),
    .ex_isig(o_isig[0]), .ex_swap(o_swap[0]), .ex_branch(o_branch[0]),
    .ex_memto_reg(o_memto_reg[0]), .ex_mem_write(o_mem_write[0]), .ex_alu_src(o_alu_src[0]),
    .ex_reg_write(o_reg_write[0]), .ex_jump(o_jump[0]), .ex_alu_op(o_alu_op[0]),
    .ex_dst(o_dst[0]), .stall_cnt(o_cnt0));

  control_pipe #(.LDLAT(2), .CNTW(4)) u_lat2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .func(func),
    .src_a(src_a), .src_b(src_b), .dst_addr(dst_addr), .branch_taken(branch_taken),
    .stall_f(o_stall[1]), .ex_valid(o_valid[1]), .ex_reg_dst(o_reg_dst[1]), .ex_ls(o_ls[1]),
    .ex_isig(o_isig[1]), .ex_swap(o_swap[1]), .ex_branch(o_branch[1]),
    .ex_memto_reg(o_memto_reg[1]), .ex_mem_write(o_mem_write[1]), .ex_alu_src(o_alu_src[1]),
    .ex_reg_write(o_reg_write[1]), .ex_jump(o_jump[1]), .ex_alu_op(o_alu_op[1]),
    .ex_dst(o_dst[1]), .stall_cnt(o_cnt1));

  control_pipe #(.LDLAT(0), .CNTW(16)) u_lat0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .func(func),
    .src_a(src_a), .src_b(src_b), .dst_addr(dst_addr), .branch_taken(branch_taken),
    .stall_f(o_stall[2]), .ex_valid(o_valid[2]), .ex_reg_dst(o_reg_dst[2]), .ex_ls(o_ls[2]),
    .ex_isig(o_isig[2]), .ex_swap(o_swap[2]), .ex_branch(o_branch[2]),
    .ex_memto_reg(o_memto_reg[2]), .ex_mem_write(o_mem_write[2]), .ex_alu_src(o_alu_src[2]),
    .ex_reg_write(o_reg_write[2]), .ex_jump(o_jump[2]), .ex_alu_op(o_alu_op[2]),
    .ex_dst(o_dst[2]), .stall_cnt(o_cnt2));

  // flags = {reg_dst, ls, isig, swap, branch, memto_reg, mem_write, alu_src, reg_write, jump}
  typedef struct packed {
    logic       valid;
    logic [9:0] flags;
    logic [2:0] alu_op;
    logic [2:0] dst;
  } bundle_t;

  int checks = 0;
  int failures = 0;

  // Reference model: the instruction sitting in EX, MWAIT cycles still owed, stall count.
  bundle_t m_ex [3];
  int      m_wait [3];
  int      m_cnt [3];
  int      lat [3]  = '{1, 2, 0};
  int      cmax [3] = '{65535, 15, 65535};

  function automatic logic [9:0] flags_of(input logic [2:0] op, input logic [1:0] f);
    case (op)
      3'd0:    return 10'b10_0000_0010;
      3'd1:    return 10'b00_0010_0100;
      3'd2:    return 10'b10_0000_0010;
      3'd3:    return 10'b10_0000_0110;
      3'd4:    return 10'b01_1001_0110;
      3'd5:    return 10'b00_1100_1100;
      3'd6:    return 10'b00_0000_0001;
      default: return (f == 2'b10) ? 10'b10_0100_0010 : 10'b10_1000_0010;
    endcase
  endfunction

  function automatic bundle_t ref_decode();
    bundle_t b;
    b = '0;
    if (in_valid) begin
      b.valid  = 1'b1;
      b.flags  = flags_of(opcode, func);
      b.alu_op = opcode;
      b.dst    = dst_addr;
    end
    return b;
  endfunction

  function automatic bit ref_hazard(input int i);
    return m_ex[i].valid && m_ex[i].flags[8] && m_ex[i].flags[1] && in_valid &&
           (m_ex[i].dst == src_a || m_ex[i].dst == src_b);
  endfunction

  function automatic bit ref_stall(input int i);
    if (m_wait[i] > 0) return 1'b1;
    if (branch_taken)  return 1'b0;
    return ref_hazard(i);
  endfunction

  task automatic ref_edge(input int i, input bit st);
    if (st && m_cnt[i] < cmax[i]) m_cnt[i]++;
    if (m_wait[i] > 0) begin
      m_wait[i]--;
    end else if (branch_taken || ref_hazard(i)) begin
      m_ex[i] = '0;
    end else begin
      m_ex[i] = ref_decode();
      if (m_ex[i].valid && m_ex[i].flags[8]) m_wait[i] = lat[i];
    end
  endtask

  function automatic bundle_t observed(input int i);
    bundle_t b;
    b.valid  = o_valid[i];
    b.flags  = {o_reg_dst[i], o_ls[i], o_isig[i], o_swap[i], o_branch[i], o_memto_reg[i],
                o_mem_write[i], o_alu_src[i], o_reg_write[i], o_jump[i]};
    b.alu_op = o_alu_op[i];
    b.dst    = o_dst[i];
    return b;
  endfunction

  function automatic int observed_cnt(input int i);
    case (i)
      0:       return int'(o_cnt0);
      1:       return int'(o_cnt1);
      default: return int'(o_cnt2);
    endcase
  endfunction

  task automatic set_id(input bit v, input logic [2:0] op, input logic [1:0] f,
                        input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                        input bit bt);
    in_valid = v; opcode = op; func = f; src_a = a; src_b = b; dst_addr = d; branch_taken = bt;
  endtask

  // One clock: compare StallF before the edge, then the registered outputs after it.
  task automatic tick(input string tag);
    bit st [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      st[i] = ref_stall(i);
      checks++;
      if (o_stall[i] !== st[i]) begin
        failures++;
        $display("FAIL %s dut%0d stall_f got=%0b exp=%0b", tag, i, o_stall[i], st[i]);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) ref_edge(i, st[i]);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (observed(i) !== m_ex[i]) begin
        failures++;
        $display("FAIL %s dut%0d ex_bundle got=%h exp=%h", tag, i, observed(i), m_ex[i]);
      end
      checks++;
      if (observed_cnt(i) != m_cnt[i]) begin
        failures++;
        $display("FAIL %s dut%0d stall_cnt got=%0d exp=%0d", tag, i, observed_cnt(i), m_cnt[i]);
      end
    end
  endtask

  // Asserts reset between edges and checks the asynchronous clear before any edge.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0; m_wait[i] = 0; m_cnt[i] = 0;
      checks++;
      if (observed(i) !== '0 || o_stall[i] !== 1'b0 || observed_cnt(i) != 0) begin
        failures++;
        $display("FAIL %s dut%0d async_clear ex=%h stall=%0b cnt=%0d exp all zero",
                 tag, i, observed(i), o_stall[i], observed_cnt(i));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = '0; m_wait[i] = 0; m_cnt[i] = 0;
      checks++;
      if (observed(i) !== '0 || o_stall[i] !== 1'b0 || observed_cnt(i) != 0) begin
        failures++;
        $display("FAIL reset_initial dut%0d ex=%h stall=%0b cnt=%0d exp all zero",
                 i, observed(i), o_stall[i], observed_cnt(i));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_id(1, 3'd0, 2'b00, 3'd1, 3'd2, 3'd3, 0);
    tick("reset_first");
    checks++;
    if (o_valid[0] !== 1'b1 || o_reg_dst[0] !== 1'b1 || o_alu_op[0] !== 3'd0) begin
      failures++;
      $display("FAIL reset_first_rtype valid=%0b reg_dst=%0b alu_op=%0d exp 1 1 0",
               o_valid[0], o_reg_dst[0], o_alu_op[0]);
    end
    // Build up pipeline state and stall counts, then reset in the middle of it.
    set_id(1, 3'd4, 2'b00, 3'd0, 3'd0, 3'd1, 0);
    tick("reset_stream");
    set_id(1, 3'd0, 2'b00, 3'd1, 3'd1, 3'd2, 0);
    tick("reset_stream");
    apply_reset("reset_mid");
  endtask

  task automatic test_decode_sweep();
    apply_reset("sweep_rst");
    for (int op = 0; op < 8; op++) begin
      set_id(1, 3'(op), 2'b00, 3'd7, 3'd7, 3'(op), 0);
      tick("sweep");
    end
    set_id(1, 3'd7, 2'b10, 3'd7, 3'd7, 3'd5, 0);
    tick("sweep_i_f10");
    checks++;
    if (o_swap[2] !== 1'b1 || o_isig[2] !== 1'b0 || o_reg_dst[2] !== 1'b1) begin
      failures++;
      $display("FAIL sweep_i_f10 swap=%0b isig=%0b reg_dst=%0b exp 1 0 1",
               o_swap[2], o_isig[2], o_reg_dst[2]);
    end
    set_id(1, 3'd7, 2'b00, 3'd7, 3'd7, 3'd5, 0);
    tick("sweep_i_f00");
    checks++;
    if (o_swap[2] !== 1'b0 || o_isig[2] !== 1'b1) begin
      failures++;
      $display("FAIL sweep_i_f00 swap=%0b isig=%0b exp 0 1", o_swap[2], o_isig[2]);
    end
    set_id(0, 3'd0, 2'b00, 3'd0, 3'd0, 3'd0, 0);
    tick("sweep_nop");
  endtask

  task automatic test_load_use_lat2();
    apply_reset("lat2_rst");
    set_id(1, 3'd4, 2'b00, 3'd0, 3'd0, 3'd3, 0);
    tick("lat2_load");
    set_id(1, 3'd0, 2'b00, 3'd3, 3'd0, 3'd1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick("lat2_dep");
      if (k == 3) begin
        checks++;
        if (o_valid[1] !== 1'b0) begin
          failures++;
          $display("FAIL lat2_bubble ex_valid got=%0b exp=0", o_valid[1]);
        end
      end
    end
    checks++;
    if (o_valid[1] !== 1'b1 || o_reg_dst[1] !== 1'b1 || o_dst[1] !== 3'd1 || o_cnt1 !== 4'd3) begin
      failures++;
      $display("FAIL lat2_arrive valid=%0b reg_dst=%0b dst=%0d cnt=%0d exp 1 1 1 3",
               o_valid[1], o_reg_dst[1], o_dst[1], o_cnt1);
    end
    set_id(0, 3'd0, 2'b00, 3'd0, 3'd0, 3'd0, 0);
    tick("lat2_tail");
  endtask

  task automatic test_load_use_lat0();
    apply_reset("lat0_rst");
    set_id(1, 3'd4, 2'b00, 3'd0, 3'd0, 3'd2, 0);
    tick("lat0_load");
    set_id(1, 3'd0, 2'b00, 3'd1, 3'd2, 3'd6, 0);
    tick("lat0_dep");
    checks++;
    if (o_valid[2] !== 1'b0) begin
      failures++;
      $display("FAIL lat0_bubble ex_valid got=%0b exp=0", o_valid[2]);
    end
    tick("lat0_dep");
    checks++;
    if (o_valid[2] !== 1'b1 || o_dst[2] !== 3'd6 || o_cnt2 !== 16'd1) begin
      failures++;
      $display("FAIL lat0_arrive valid=%0b dst=%0d cnt=%0d exp 1 6 1", o_valid[2], o_dst[2], o_cnt2);
    end
    apply_reset("lat0_rst2");
    set_id(1, 3'd4, 2'b00, 3'd0, 3'd0, 3'd2, 0);
    tick("lat0_load2");
    set_id(1, 3'd0, 2'b00, 3'd5, 3'd5, 3'd6, 0);
    tick("lat0_indep");
    checks++;
    if (o_valid[2] !== 1'b1 || o_cnt2 !== 16'd0) begin
      failures++;
      $display("FAIL lat0_no_bubble valid=%0b cnt=%0d exp 1 0", o_valid[2], o_cnt2);
    end
  endtask

  task automatic test_branch_flush();
    apply_reset("flush_rst");
    set_id(1, 3'd4, 2'b00, 3'd0, 3'd0, 3'd2, 0);
    tick("flush_load");
    set_id(1, 3'd0, 2'b00, 3'd2, 3'd2, 3'd4, 1);
    #1;
    checks++;
    if (o_stall[2] !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall stall_f got=%0b exp=0", o_stall[2]);
    end
    tick("flush_edge");
    checks++;
    if (o_valid[2] !== 1'b0 || o_cnt2 !== 16'd0) begin
      failures++;
      $display("FAIL flush_bubble valid=%0b cnt=%0d exp 0 0", o_valid[2], o_cnt2);
    end
    set_id(0, 3'd0, 2'b00, 3'd0, 3'd0, 3'd0, 0);
    tick("flush_tail");
  endtask

  task automatic test_reset_in_mwait();
    apply_reset("mwait_rst");
    set_id(1, 3'd4, 2'b00, 3'd0, 3'd0, 3'd3, 0);
    tick("mwait_load");
    set_id(1, 3'd2, 2'b00, 3'd1, 3'd1, 3'd5, 0);
    tick("mwait_hold");
    apply_reset("mwait_abort");
    tick("mwait_after");
    checks++;
    if (o_valid[1] !== 1'b1 || o_alu_op[1] !== 3'd2) begin
      failures++;
      $display("FAIL mwait_after valid=%0b alu_op=%0d exp 1 2", o_valid[1], o_alu_op[1]);
    end
  endtask

  task automatic test_saturation();
    apply_reset("sat_rst");
    set_id(1, 3'd4, 2'b00, 3'd1, 3'd1, 3'd1, 0);
    for (int k = 0; k < 40; k++) tick("sat_run");
    checks++;
    if (o_cnt1 !== 4'd15) begin
      failures++;
      $display("FAIL sat_cnt4 got=%0d exp=15", o_cnt1);
    end
  endtask

  task automatic test_random();
    apply_reset("rand_rst");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) apply_reset("rand_reset");
      set_id(($urandom_range(0, 7) != 0),
             ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)),
             3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0));
      tick("random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode_sweep();
    test_load_use_lat2();
    test_load_use_lat0();
    test_branch_flush();
    test_reset_in_mwait();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
